// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : round-robin icache/dcache arbiter for one burst memory port
// rev 1.0
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int BEATS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ic_req_i,
    input  logic [31:0]                ic_addr_i,
    input  logic                       dc_req_i,
    input  logic                       dc_we_i,
    input  logic [31:0]                dc_addr_i,
    input  logic [31:0]                dc_wdata_i,
    output logic                       dc_wnext_o,
    output logic                       ic_rvalid_o,
    output logic                       dc_rvalid_o,
    output logic [31:0]                rdata_o,
    output logic [$clog2(BEATS)-1:0]   rbeat_o,
    output logic                       ic_done_o,
    output logic                       dc_done_o,
    output logic                       mem_req_valid_o,
    input  logic                       mem_req_ready_i,
    output logic                       mem_req_rnw_o,
    output logic [31:0]                mem_req_addr_o,
    output logic [31:0]                mem_wdata_o,
    output logic                       mem_wdata_valid_o,
    input  logic                       mem_wdata_ready_i,
    input  logic [31:0]                mem_rdata_i,
    input  logic                       mem_rdata_valid_i,
    output logic                       stall_o
);

    localparam int              BW        = $clog2(BEATS);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
    localparam logic [31:0]     ADDR_MASK = ~32'(BEATS * 4 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_WDATA = 3'd2,
        S_RDATA = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;     // 1 = dcache owns the port
    logic          last_q,  last_d;      // 1 = dcache was granted last
    logic          rnw_q,   rnw_d;
    logic [31:0]   addr_q,  addr_d;
    logic [BW-1:0] beat_q,  beat_d;
    logic          pick_dc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
        end
    end

    // On a tie the dcache wins unless it was the previous owner.
    assign pick_dc = dc_req_i & (~ic_req_i | ~last_q);

    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        last_d            = last_q;
        rnw_d             = rnw_q;
        addr_d            = addr_q;
        beat_d            = beat_q;
        mem_req_valid_o   = 1'b0;
        mem_wdata_valid_o = 1'b0;
        mem_wdata_o       = '0;
        dc_wnext_o        = 1'b0;
        ic_rvalid_o       = 1'b0;
        dc_rvalid_o       = 1'b0;
        rdata_o           = '0;
        rbeat_o           = '0;
        ic_done_o         = 1'b0;
        dc_done_o         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ic_req_i | dc_req_i) begin
                    owner_d = pick_dc;
                    rnw_d   = ~(pick_dc & dc_we_i);
                    addr_d  = (pick_dc ? dc_addr_i : ic_addr_i) & ADDR_MASK;
                    beat_d  = '0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = rnw_q ? S_RDATA : S_WDATA;
                end
            end
            S_WDATA: begin
                mem_wdata_valid_o = 1'b1;
                mem_wdata_o       = dc_wdata_i;
                if (mem_wdata_ready_i) begin
                    dc_wnext_o = 1'b1;
                    beat_d     = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RDATA: begin
                if (mem_rdata_valid_i) begin
                    rdata_o     = mem_rdata_i;
                    rbeat_o     = beat_q;
                    ic_rvalid_o = ~owner_q;
                    dc_rvalid_o = owner_q;
                    beat_d      = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ic_done_o = ~owner_q;
                dc_done_o = owner_q;
                last_d    = owner_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_req_rnw_o  = rnw_q;
    assign mem_req_addr_o = addr_q;
    assign stall_o        = (ic_req_i & ~ic_done_o) | (dc_req_i & ~dc_done_o);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter : directed bench with a transaction-level arbiter model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int BEATS = 4;
    localparam int BW    = $clog2(BEATS);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_req = 1'b0;
    logic [31:0]   ic_addr = '0;
    logic          dc_req = 1'b0;
    logic          dc_we = 1'b0;
    logic [31:0]   dc_addr = '0;
    logic [31:0]   dc_wdata = '0;
    logic          mem_req_ready = 1'b0;
    logic          mem_wdata_ready = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          rv_auto = 1'b0;
    logic          rv_force = 1'b0;
    logic          mem_rdata_valid;

    logic          dc_wnext, ic_rvalid, dc_rvalid, ic_done, dc_done;
    logic [31:0]   rdata, mem_req_addr, mem_wdata;
    logic [BW-1:0] rbeat;
    logic          mem_req_valid, mem_req_rnw, mem_wdata_valid, stall;

    assign mem_rdata_valid = rv_auto | rv_force;

    always #5 clk = ~clk;

    mem_arbiter #(.BEATS(BEATS)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ic_req_i          (ic_req),
        .ic_addr_i         (ic_addr),
        .dc_req_i          (dc_req),
        .dc_we_i           (dc_we),
        .dc_addr_i         (dc_addr),
        .dc_wdata_i        (dc_wdata),
        .dc_wnext_o        (dc_wnext),
        .ic_rvalid_o       (ic_rvalid),
        .dc_rvalid_o       (dc_rvalid),
        .rdata_o           (rdata),
        .rbeat_o           (rbeat),
        .ic_done_o         (ic_done),
        .dc_done_o         (dc_done),
        .mem_req_valid_o   (mem_req_valid),
        .mem_req_ready_i   (mem_req_ready),
        .mem_req_rnw_o     (mem_req_rnw),
        .mem_req_addr_o    (mem_req_addr),
        .mem_wdata_o       (mem_wdata),
        .mem_wdata_valid_o (mem_wdata_valid),
        .mem_wdata_ready_i (mem_wdata_ready),
        .mem_rdata_i       (mem_rdata),
        .mem_rdata_valid_i (mem_rdata_valid),
        .stall_o           (stall)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction model: one outstanding line transfer at a time.
    bit          m_busy, m_cmd, m_xfer, m_fin, m_dc, m_wr, m_last_dc;
    logic [31:0] m_line;
    int          m_cnt;

    // Observations of the DUT used for the literal checks.
    logic [31:0] ic_data[$];
    int          ic_beat[$];
    logic [31:0] wn_data[$];
    int          done_order[$];
    int          n_ic_done, n_dc_done, n_wnext, n_valid_cyc, n_stall_cmd;
    int          last_ic_rv_cyc, ic_done_cyc;
    logic [31:0] seen_addr;
    logic        seen_rnw;

    task automatic clear_obs();
        ic_data.delete(); ic_beat.delete(); wn_data.delete(); done_order.delete();
        n_ic_done = 0; n_dc_done = 0; n_wnext = 0; n_valid_cyc = 0; n_stall_cmd = 0;
        last_ic_rv_cyc = 0; ic_done_cyc = 0; seen_addr = 'x; seen_rnw = 'x;
    endtask

    always @(negedge clk) begin
        logic e_rv, e_wn, e_icd, e_dcd;
        cyc++;
        if (!rst_n) begin
            m_busy = 0; m_cmd = 0; m_xfer = 0; m_fin = 0; m_dc = 0; m_wr = 0;
            m_last_dc = 0; m_line = '0; m_cnt = 0;
        end
        e_rv  = m_xfer && !m_wr && mem_rdata_valid;
        e_wn  = m_xfer && m_wr && mem_wdata_ready;
        e_icd = m_fin && !m_dc;
        e_dcd = m_fin && m_dc;

        chk("mem_req_valid", 32'(mem_req_valid), 32'(m_cmd));
        if (m_cmd) begin
            chk("mem_req_addr", mem_req_addr, m_line);
            chk("mem_req_rnw", 32'(mem_req_rnw), 32'(!m_wr));
        end
        chk("mem_wdata_valid", 32'(mem_wdata_valid), 32'(m_xfer && m_wr));
        chk("mem_wdata", mem_wdata, (m_xfer && m_wr) ? dc_wdata : 32'h0);
        chk("dc_wnext", 32'(dc_wnext), 32'(e_wn));
        chk("ic_rvalid", 32'(ic_rvalid), 32'(e_rv && !m_dc));
        chk("dc_rvalid", 32'(dc_rvalid), 32'(e_rv && m_dc));
        chk("rdata", rdata, e_rv ? mem_rdata : 32'h0);
        chk("rbeat", 32'(rbeat), e_rv ? 32'(m_cnt) : 32'h0);
        chk("ic_done", 32'(ic_done), 32'(e_icd));
        chk("dc_done", 32'(dc_done), 32'(e_dcd));
        chk("stall", 32'(stall), 32'((ic_req && !e_icd) || (dc_req && !e_dcd)));

        if (ic_rvalid) begin
            ic_data.push_back(rdata); ic_beat.push_back(int'(rbeat)); last_ic_rv_cyc = cyc;
        end
        if (ic_done) begin done_order.push_back(0); n_ic_done++; ic_done_cyc = cyc; end
        if (dc_done) begin done_order.push_back(1); n_dc_done++; end
        if (dc_wnext) begin n_wnext++; wn_data.push_back(mem_wdata); end
        if (mem_req_valid) begin
            n_valid_cyc++; seen_addr = mem_req_addr; seen_rnw = mem_req_rnw;
            if (stall) n_stall_cmd++;
        end

        if (rst_n) begin
            if (!m_busy) begin
                if (ic_req || dc_req) begin
                    m_dc   = dc_req && (!ic_req || !m_last_dc);
                    m_wr   = m_dc && dc_we;
                    m_line = (m_dc ? dc_addr : ic_addr) & ~32'(BEATS * 4 - 1);
                    m_busy = 1; m_cmd = 1; m_cnt = 0;
                end
            end else if (m_cmd) begin
                if (mem_req_ready) begin m_cmd = 0; m_xfer = 1; end
            end else if (m_xfer) begin
                if (m_wr ? mem_wdata_ready : mem_rdata_valid) begin
                    if (m_cnt == BEATS - 1) begin m_xfer = 0; m_fin = 1; m_cnt = 0; end
                    else m_cnt++;
                end
            end else if (m_fin) begin
                m_fin = 0; m_busy = 0; m_last_dc = m_dc;
            end
        end
    end

    // Requesters release req the cycle after their done pulse.
    initial forever begin
        @(negedge clk);
        if (ic_done) begin @(posedge clk); #1; ic_req = 1'b0; end
    end
    initial forever begin
        @(negedge clk);
        if (dc_done) begin @(posedge clk); #1; dc_req = 1'b0; end
    end
    initial forever begin
        @(negedge clk);
        if (dc_wnext) begin @(posedge clk); #1; dc_wdata = dc_wdata + 32'd1; end
    end

    // Memory responder.
    int          ready_delay = 0;
    bit          wr_toggle = 0;
    bit          rd_gap = 0;
    logic [31:0] rd_base = '0;
    initial begin : mem_model
        bit new_rd, wtog, gtog;
        int wait_cnt, reads_left, rd_idx;
        wtog = 1; gtog = 0; wait_cnt = 0; reads_left = 0; rd_idx = 0;
        forever begin
            @(negedge clk);
            new_rd = rst_n && mem_req_valid && mem_req_ready && mem_req_rnw;
            if (!rst_n) reads_left = 0;
            @(posedge clk); #1;
            if (rv_auto && reads_left > 0) begin reads_left--; rd_idx++; end
            rv_auto = 1'b0;
            if (!rst_n) reads_left = 0;
            if (new_rd) begin reads_left = BEATS; rd_idx = 0; gtog = 0; end
            if (reads_left > 0) begin
                if (rd_gap) begin rv_auto = gtog; gtog = !gtog; end
                else rv_auto = 1'b1;
                mem_rdata = rd_base + 32'(rd_idx);
            end
            if (mem_req_valid) begin
                mem_req_ready = (wait_cnt >= ready_delay); wait_cnt++;
            end else begin
                mem_req_ready = 1'b0; wait_cnt = 0;
            end
            if (mem_wdata_valid) begin
                mem_wdata_ready = wr_toggle ? wtog : 1'b1; wtog = !wtog;
            end else begin
                mem_wdata_ready = 1'b0; wtog = 1;
            end
        end
    end

    task automatic wait_quiet(input string nm);
        int k = 0;
        while ((ic_req || dc_req) && k < 300) begin @(posedge clk); #1; k++; end
        chk({nm, " timeout"}, 32'(ic_req || dc_req), 32'h0);
        ic_req = 1'b0; dc_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_ic_beats(input string nm, input logic [31:0] base);
        chk({nm, " beat count"}, 32'(ic_data.size()), 32'(BEATS));
        for (int i = 0; i < BEATS; i++) begin
            chk({nm, " rdata"}, (i < ic_data.size()) ? ic_data[i] : 32'hDEAD_BEEF, base + 32'(i));
            chk({nm, " rbeat"}, (i < ic_beat.size()) ? 32'(ic_beat[i]) : 32'hFFFF, 32'(i));
        end
    endtask

    initial begin
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset mem_req_valid", 32'(mem_req_valid), 32'h0);
        chk("reset mem_req_addr", mem_req_addr, 32'h0);
        chk("reset rnw", 32'(mem_req_rnw), 32'h0);
        ic_req = 1'b1;
        #1;
        chk("reset stall follows req", 32'(stall), 32'h1);
        ic_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Tie straight after reset, then again: dcache wins both times.
        clear_obs(); rd_base = 32'h50; rd_gap = 1;
        ic_addr = 32'h100; dc_addr = 32'h200; dc_we = 1'b0; ic_req = 1'b1; dc_req = 1'b1;
        wait_quiet("tie1");
        ic_addr = 32'h140; dc_addr = 32'h240; ic_req = 1'b1; dc_req = 1'b1;
        wait_quiet("tie2");
        chk("tie done count", 32'(done_order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("tie grant order", (i < done_order.size()) ? 32'(done_order[i]) : 32'hF, (i % 2 == 0) ? 32'd1 : 32'd0);
        rd_gap = 0;

        // Icache line fill.
        clear_obs(); rd_base = 32'hA0;
        ic_addr = 32'h0000_1234; ic_req = 1'b1;
        wait_quiet("ic fill");
        chk("ic fill line addr", seen_addr, 32'h0000_1230);
        chk("ic fill rnw", 32'(seen_rnw), 32'h1);
        chk_ic_beats("ic fill", 32'hA0);
        chk("ic fill done count", 32'(n_ic_done), 32'd1);
        chk("ic_done latency", 32'(ic_done_cyc - last_ic_rv_cyc), 32'd1);

        // Dcache writeback with toggling write-ready.
        clear_obs(); wr_toggle = 1;
        dc_addr = 32'h40; dc_we = 1'b1; dc_wdata = 32'hD0; dc_req = 1'b1;
        wait_quiet("wb");
        chk("wb addr", seen_addr, 32'h40);
        chk("wb rnw", 32'(seen_rnw), 32'h0);
        chk("wb wnext count", 32'(n_wnext), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("wb beat data", (i < wn_data.size()) ? wn_data[i] : 32'hDEAD_BEEF, 32'hD0 + 32'(i));
        chk("wb done count", 32'(n_dc_done), 32'd1);
        wr_toggle = 0; dc_we = 1'b0;

        // Command channel held off for ten cycles.
        clear_obs(); ready_delay = 10; rd_base = 32'h10;
        ic_addr = 32'h2008; ic_req = 1'b1;
        wait_quiet("hold");
        chk("hold valid cycles", 32'(n_valid_cyc), 32'd11);
        chk("hold stall cycles", 32'(n_stall_cmd), 32'd11);
        chk("hold addr", seen_addr, 32'h2000);
        chk_ic_beats("hold", 32'h10);

        // Stray read-valid pulses in IDLE and CMD.
        clear_obs(); ready_delay = 3; rd_base = 32'h70;
        rv_force = 1'b1; @(posedge clk); #1; rv_force = 1'b0;
        ic_addr = 32'h0000_7010; ic_req = 1'b1;
        for (int k = 0; k < 20 && !mem_req_valid; k++) begin @(posedge clk); #1; end
        rv_force = 1'b1; @(posedge clk); #1; rv_force = 1'b0;
        wait_quiet("stray");
        chk_ic_beats("stray", 32'h70);

        // Reset during the third read beat, then a clean fill.
        clear_obs(); ready_delay = 0; rd_base = 32'hC0;
        ic_addr = 32'h3000; ic_req = 1'b1;
        for (int k = 0; k < 50 && ic_data.size() < 2; k++) begin @(posedge clk); #1; end
        rst_n = 1'b0; ic_req = 1'b0;
        #1;
        chk("mid-reset ic_rvalid", 32'(ic_rvalid), 32'h0);
        chk("mid-reset rdata", rdata, 32'h0);
        chk("mid-reset addr", mem_req_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid-reset no done", 32'(n_ic_done), 32'd0);
        clear_obs(); rd_base = 32'hE0;
        ic_addr = 32'h3040; ic_req = 1'b1;
        wait_quiet("after reset");
        chk_ic_beats("after reset", 32'hE0);
        chk("after reset done count", 32'(n_ic_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: BEATS, default 4, meaning 32-bit beats per line burst (power of two, 2..16).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 ic_req  in  1  icache line-fill request; held high until ic_done.
REQ-005 ic_addr  in  32  icache fill byte address; stable while ic_req high.
REQ-006 dc_req  in  1  dcache request; held high until dc_done.
REQ-007 dc_we  in  1  1 = line writeback, 0 = line fill; stable while dc_req high.
REQ-008 dc_addr  in  32  dcache byte address; stable while dc_req high.
REQ-009 dc_wdata  in  32  current writeback beat.
REQ-010 dc_wnext  out  1  writeback beat accepted; dcache presents next beat on the following cycle.
REQ-011 ic_rvalid, dc_rvalid  out  1  fill beat valid for that requester.
REQ-012 rdata  out  32  fill beat data, shared by both requesters; rbeat  out  log2(BEATS)  beat index.
REQ-013 ic_done, dc_done  out  1  one-cycle transaction-complete pulse.
REQ-014 mem_req_valid  out  1 / mem_req_ready  in  1 / mem_req_rnw  out  1 / mem_req_addr  out  32  memory command channel.
REQ-015 mem_wdata  out  32 / mem_wdata_valid  out  1 / mem_wdata_ready  in  1  memory write-data channel.
REQ-016 mem_rdata  in  32 / mem_rdata_valid  in  1  memory read-return channel; no backpressure.
REQ-017 stall  out  1  CPU pipeline stall.

Function
REQ-018 FSM states: IDLE, CMD, WDATA, RDATA, DONE.
REQ-019 IDLE: a pending request is granted; owner, rnw, and address are latched; next state CMD. With no request, remain in IDLE.
REQ-020 Arbitration is round-robin on last_grant. On simultaneous ic_req and dc_req, grant the requester that is not last_grant. A single requester is always granted.
REQ-021 Latched address is line-aligned: low log2(BEATS*4) bits are forced to zero on mem_req_addr.
REQ-022 mem_req_rnw = 0 only for a dcache request with dc_we = 1.
REQ-023 CMD: mem_req_valid = 1, holding address and rnw constant, until mem_req_ready. On ready, next state is WDATA if write, else RDATA.
REQ-024 WDATA: mem_wdata = dc_wdata and mem_wdata_valid = 1.
  - On each mem_wdata_ready cycle: pulse dc_wnext and increment the beat counter.
  - After beat BEATS-1 is accepted: go to DONE.
REQ-025 RDATA: on each mem_rdata_valid cycle, rdata = mem_rdata and rbeat = beat counter, both combinational from the inputs/counter, and the owner's rvalid = 1 in the same cycle.
  - The counter increments; after beat BEATS-1: go to DONE.
REQ-026 The beat counter is log2(BEATS) bits, cleared on grant, and wraps to 0 after BEATS-1.
REQ-027 DONE: the owner's done = 1 for exactly one cycle; last_grant = owner; next state IDLE.
REQ-028 A requester drops req in the cycle after its done pulse. If req is still high in IDLE, it is treated as a new request.
REQ-029 mem_rdata_valid outside RDATA is ignored: no rvalid, no counter change.
REQ-030 mem_wdata_ready outside WDATA is ignored.
REQ-031 stall = (ic_req & ~ic_done) | (dc_req & ~dc_done), combinational.
REQ-032 A request arriving during another requester's transaction waits in IDLE; there is no preemption.
REQ-033 Minimum transaction length: 1 (IDLE) + 1 (CMD) + BEATS + 1 (DONE) cycles.

Reset
REQ-034 rst_n low:
  - state goes to IDLE asynchronously;
  - beat counter = 0;
  - last_grant = icache, so dcache wins the first tie;
  - latched address/rnw = 0.
REQ-035 All outputs are 0 during reset except stall, which still follows REQ-031.
REQ-036 Reset mid-burst discards the transaction without a done pulse. The memory-side protocol after reset is the memory model's responsibility.

Verification
REQ-037 Icache fill, BEATS=4, ic_addr=0x0000_1234: mem_req_addr=0x0000_1230, rnw=1. Returns 0xA0..0xA3 give ic_rvalid x4 with rbeat 0..3, then ic_done one cycle after the last beat.
REQ-038 Dcache writeback, dc_addr=0x40, mem_wdata_ready toggling 1,0,1,0: dc_wnext exactly 4 times; mem_wdata tracks dc_wdata; dc_done after the 4th accept.
REQ-039 ic_req and dc_req asserted in the same cycle after reset: dcache granted first, icache second. Repeat the tie: dcache first again, since last_grant=icache after the icache transaction.
REQ-040 mem_req_ready held low 10 cycles: mem_req_valid, mem_req_addr, and rnw are stable all 10 cycles; stall stays 1.
REQ-041 rst_n pulsed low during RDATA beat 2: all outputs drop immediately with no ic_done. A new ic_req afterwards completes normally with rbeat starting at 0.
REQ-042 mem_rdata_valid pulsed in IDLE and CMD: no rvalid and no rbeat change.
